// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - seven-segment scan bus monitor that rebuilds 4-digit hex frames
// Optional macro SEGDEC_DP_CAPTURE_EN: capture decimal points and include them in the stability compare.
module seg_scan_decoder #(
    parameter int STABLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 200000,
    parameter bit SEL_ACTIVE_LOW = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  sel,
    input  logic [7:0]  seg,
    output logic [15:0] out_value,
    output logic [3:0]  out_digit_ok,
    output logic [3:0]  out_dp,
    output logic        out_valid,
    input  logic        out_ready,
    input  logic        err_clr,
    output logic        err_pattern,
    output logic        err_overrun,
    output logic        stale
);
    localparam int SCW = $clog2(STABLE_CYCLES + 1);
    localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SCW-1:0] STABLE_MAX  = SCW'(STABLE_CYCLES);
    localparam logic [SCW-1:0] CAPTURE_AT  = SCW'(STABLE_CYCLES - 2);
    localparam logic [TOW-1:0] TIMEOUT_MAX = TOW'(TIMEOUT_CYCLES);

    typedef enum logic [0:0] {
        ST_COLLECT = 1'b0,
        ST_HOLD    = 1'b1
    } state_t;

    // {illegal, ok, nibble}; blank (7F) is neither ok nor illegal
    function automatic logic [5:0] decode_glyph(input logic [6:0] g);
        logic [5:0] r;
        r = 6'b00_0000;
        case (g)
            7'h40:   r = {2'b01, 4'h0};
            7'h79:   r = {2'b01, 4'h1};
            7'h24:   r = {2'b01, 4'h2};
            7'h30:   r = {2'b01, 4'h3};
            7'h19:   r = {2'b01, 4'h4};
            7'h12:   r = {2'b01, 4'h5};
            7'h02:   r = {2'b01, 4'h6};
            7'h78:   r = {2'b01, 4'h7};
            7'h00:   r = {2'b01, 4'h8};
            7'h10:   r = {2'b01, 4'h9};
            7'h08:   r = {2'b01, 4'hA};
            7'h03:   r = {2'b01, 4'hB};
            7'h46:   r = {2'b01, 4'hC};
            7'h21:   r = {2'b01, 4'hD};
            7'h06:   r = {2'b01, 4'hE};
            7'h0E:   r = {2'b01, 4'hF};
            7'h7F:   r = 6'b00_0000;
            default: r = 6'b10_0000;
        endcase
        return r;
    endfunction

    logic [3:0]     sel_s1_q, sel_s2_q;
    logic [7:0]     seg_s1_q, seg_s2_q;
    logic [3:0]     sel_n;
    logic [7:0]     seg_cmp;
    logic [11:0]    sample;
    logic [11:0]    prev_q;
    logic [SCW-1:0] stab_q, stab_d;
    logic [TOW-1:0] to_q, to_d;
    logic           sel_one_hot;
    logic           capture;
    logic [1:0]     cap_idx;
    logic [5:0]     dec;
    logic [3:0]     seen_q, seen_d;
    logic [15:0]    coll_val_q;
    logic [3:0]     coll_ok_q;
    logic [15:0]    out_val_q;
    logic [3:0]     out_ok_q;
    state_t         state_q, state_d;
    logic           load, drop, seen_clr, timeout_hit;
    logic           err_pattern_q, err_pattern_d;
    logic           err_overrun_q, err_overrun_d;
    logic           stale_q, stale_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_s1_q <= '0;
            sel_s2_q <= '0;
            seg_s1_q <= '0;
            seg_s2_q <= '0;
        end else begin
            sel_s1_q <= sel;
            sel_s2_q <= sel_s1_q;
            seg_s1_q <= seg;
            seg_s2_q <= seg_s1_q;
        end
    end

    assign sel_n = SEL_ACTIVE_LOW ? ~sel_s2_q : sel_s2_q;
`ifdef SEGDEC_DP_CAPTURE_EN
    assign seg_cmp = seg_s2_q;
`else
    // dp forced off so its flicker can never hold off a capture
    assign seg_cmp = seg_s2_q | 8'h80;
`endif
    assign sample      = {sel_n, seg_cmp};
    assign sel_one_hot = (sel_n != 4'd0) && ((sel_n & (sel_n - 4'd1)) == 4'd0);

    always_comb begin
        stab_d = stab_q;
        if (sample != prev_q) begin
            stab_d = '0;
        end else if (stab_q != STABLE_MAX) begin
            stab_d = stab_q + SCW'(1);
        end
    end

    // Fires once per stable period, on the STABLE-2 -> STABLE-1 step
    assign capture = (sample == prev_q) && (stab_q == CAPTURE_AT) && sel_one_hot;
    assign dec     = decode_glyph(seg_cmp[6:0]);

    always_comb begin
        case (sel_n)
            4'b0010: cap_idx = 2'd1;
            4'b0100: cap_idx = 2'd2;
            4'b1000: cap_idx = 2'd3;
            default: cap_idx = 2'd0;
        endcase
    end

    always_comb begin
        to_d = to_q;
        if (capture) begin
            to_d = '0;
        end else if (to_q != TIMEOUT_MAX) begin
            to_d = to_q + TOW'(1);
        end
    end

    // A complete frame takes precedence over a timeout
    assign timeout_hit = (to_q == TIMEOUT_MAX) && (seen_q != 4'd0) && (seen_q != 4'hF);

    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        drop     = 1'b0;
        seen_clr = 1'b0;
        case (state_q)
            ST_COLLECT: begin
                if (seen_q == 4'hF) begin
                    load     = 1'b1;
                    seen_clr = 1'b1;
                    state_d  = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    if (seen_q == 4'hF) begin
                        load     = 1'b1;
                        seen_clr = 1'b1;
                    end else begin
                        state_d = ST_COLLECT;
                    end
                end else if (seen_q == 4'hF) begin
                    drop     = 1'b1;
                    seen_clr = 1'b1;
                end
            end
            default: state_d = ST_COLLECT;
        endcase
        if (timeout_hit) begin
            seen_clr = 1'b1;
        end
    end

    always_comb begin
        seen_d = seen_clr ? 4'd0 : seen_q;
        if (capture) begin
            seen_d[cap_idx] = 1'b1;
        end
    end

    assign err_pattern_d = (capture && dec[5]) || (err_pattern_q && !err_clr);
    assign err_overrun_d = drop || (err_overrun_q && !err_clr);
    assign stale_d       = timeout_hit || (stale_q && !load);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q        <= '0;
            stab_q        <= '0;
            to_q          <= '0;
            seen_q        <= '0;
            coll_val_q    <= '0;
            coll_ok_q     <= '0;
            out_val_q     <= '0;
            out_ok_q      <= '0;
            state_q       <= ST_COLLECT;
            err_pattern_q <= 1'b0;
            err_overrun_q <= 1'b0;
            stale_q       <= 1'b0;
        end else begin
            prev_q        <= sample;
            stab_q        <= stab_d;
            to_q          <= to_d;
            seen_q        <= seen_d;
            state_q       <= state_d;
            err_pattern_q <= err_pattern_d;
            err_overrun_q <= err_overrun_d;
            stale_q       <= stale_d;
            if (capture) begin
                coll_val_q[{cap_idx, 2'b00} +: 4] <= dec[3:0];
                coll_ok_q[cap_idx]                <= dec[4];
            end
            if (load) begin
                out_val_q <= coll_val_q;
                out_ok_q  <= coll_ok_q;
            end
        end
    end

`ifdef SEGDEC_DP_CAPTURE_EN
    logic [3:0] coll_dp_q;
    logic [3:0] out_dp_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            coll_dp_q <= '0;
            out_dp_q  <= '0;
        end else begin
            if (capture) begin
                coll_dp_q[cap_idx] <= ~seg_cmp[7];
            end
            if (load) begin
                out_dp_q <= coll_dp_q;
            end
        end
    end

    assign out_dp = out_dp_q;
`else
    assign out_dp = 4'd0;
`endif

    assign out_value    = out_val_q;
    assign out_digit_ok = out_ok_q;
    assign out_valid    = (state_q == ST_HOLD);
    assign err_pattern  = err_pattern_q;
    assign err_overrun  = err_overrun_q;
    assign stale        = stale_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb/tb_seg_scan_decoder.sv - directed and randomized scan-bus checks of seg_scan_decoder
module tb_seg_scan_decoder;
    localparam int STABLE = 16;
    localparam int TO     = 1000;
    localparam logic [6:0] GLY [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  sel = 4'b0100;
    logic [7:0]  seg = 8'hA4;
    logic        out_ready = 1'b1;
    logic        err_clr = 1'b0;
    logic [15:0] out_value;
    logic [3:0]  out_digit_ok;
    logic [3:0]  out_dp;
    logic        out_valid;
    logic        err_pattern;
    logic        err_overrun;
    logic        stale;

    seg_scan_decoder #(
        .STABLE_CYCLES (STABLE),
        .TIMEOUT_CYCLES(TO),
        .SEL_ACTIVE_LOW(1'b0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sel         (sel),
        .seg         (seg),
        .out_value   (out_value),
        .out_digit_ok(out_digit_ok),
        .out_dp      (out_dp),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .err_clr     (err_clr),
        .err_pattern (err_pattern),
        .err_overrun (err_overrun),
        .stale       (stale)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int glyph_class(input logic [6:0] g);
        if (g == 7'h7F) return 16;
        for (int i = 0; i < 16; i++) if (GLY[i] == g) return i;
        return 17;
    endfunction

    // Handshake monitor, sampled just after the falling edge
    int          cyc = 0;
    int          rise_cyc = 0;
    int          cur_len = 0;
    int          last_len = 0;
    int          start_cyc = 0;
    logic        vprev = 1'b0;
    logic [23:0] got[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        #1;
        if (out_valid && out_ready) got.push_back({out_dp, out_digit_ok, out_value});
        if (out_valid && !vprev) rise_cyc = cyc;
        if (out_valid) cur_len++;
        else if (vprev) begin
            last_len = cur_len;
            cur_len  = 0;
        end
        vprev = out_valid;
    end

    task automatic drive_raw(input logic [3:0] s, input logic [7:0] g, input int n);
        sel       = s;
        seg       = g;
        start_cyc = cyc;
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input logic [3:0] s, input logic [6:0] g, input int n);
        drive_raw(s, {1'b1, g}, n);
    endtask

    task automatic scan4(input logic [6:0] g0, input logic [6:0] g1, input logic [6:0] g2,
                         input logic [6:0] g3);
        drive(4'b0001, g0, 20);
        drive(4'b0010, g1, 20);
        drive(4'b0100, g2, 20);
        drive(4'b1000, g3, 20);
    endtask

    task automatic pulse_err_clr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
    endtask

    function automatic logic [23:0] last_frame();
        if (got.size() == 0) return 24'hFFFFFF;
        return got[got.size()-1];
    endfunction

    int          n0;
    logic [23:0] f;
    logic [3:0]  m_seen;
    logic [15:0] m_val;
    logic [3:0]  m_ok;
    logic        m_err;
    logic [23:0] expq[$];

    initial begin
        repeat (5) @(negedge clk);
        check("rst_value", {16'h0, out_value}, 32'h0);
        check("rst_flags", {20'h0, out_digit_ok, out_dp, out_valid, err_pattern, err_overrun, stale}, 32'h0);
        sel   = 4'b0000;
        seg   = 8'hFF;
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Basic scan 1,2,3,4
        n0 = got.size();
        scan4(7'h79, 7'h24, 7'h30, 7'h19);
        check("t1_latency", rise_cyc - start_cyc - 1, 18);
        repeat (3) @(negedge clk);
        f = last_frame();
        check("t1_count", got.size() - n0, 1);
        check("t1_value", f[15:0], 16'h4321);
        check("t1_ok", f[19:16], 4'hF);
        check("t1_pulse", last_len, 1);
        check("t1_dp", f[23:20], 4'h0);

        // Glitching digit 2 must not capture until it settles
        n0 = got.size();
        drive(4'b0001, 7'h30, 20);
        drive(4'b0010, 7'h78, 20);
        drive(4'b1000, 7'h10, 20);
        for (int k = 0; k < 8; k++) drive(4'b0100, (k % 2 == 1) ? 7'h00 : 7'h24, 5);
        check("t2_no_capture", got.size() - n0, 0);
        drive(4'b0100, 7'h24, 25);
        f = last_frame();
        check("t2_count", got.size() - n0, 1);
        check("t2_digit2", f[11:8], 4'h2);
        check("t2_value", f[15:0], 16'h9273);

        // Blank and illegal glyphs
        check("t3_err_before", err_pattern, 0);
        n0 = got.size();
        drive(4'b0001, 7'h08, 20);
        drive(4'b0010, 7'h7F, 20);
        drive(4'b0100, 7'h46, 20);
        check("t3_blank_noerr", err_pattern, 0);
        drive(4'b1000, 7'h55, 20);
        repeat (2) @(negedge clk);
        f = last_frame();
        check("t3_count", got.size() - n0, 1);
        check("t3_ok", f[19:16], 4'b0101);
        check("t3_value", f[15:0], 16'h0C0A);
        check("t3_err_set", err_pattern, 1);
        repeat (10) @(negedge clk);
        check("t3_err_sticky", err_pattern, 1);
        pulse_err_clr();
        check("t3_err_clr", err_pattern, 0);

        // Overrun while the consumer stalls
        out_ready = 1'b0;
        n0 = got.size();
        scan4(7'h12, 7'h02, 7'h06, 7'h0E);
        check("t4_valid", out_valid, 1);
        check("t4_first", out_value, 16'hFE65);
        check("t4_no_ovr", err_overrun, 0);
        scan4(7'h79, 7'h24, 7'h30, 7'h19);
        check("t4_held", out_value, 16'hFE65);
        check("t4_ovr", err_overrun, 1);
        check("t4_no_hs", got.size() - n0, 0);
        out_ready = 1'b1;
        repeat (5) @(negedge clk);
        f = last_frame();
        check("t4_one_hs", got.size() - n0, 1);
        check("t4_hs_value", f[15:0], 16'hFE65);
        check("t4_valid_low", out_valid, 0);
        pulse_err_clr();
        check("t4_ovr_clr", err_overrun, 0);

        // Timeout discards a partial frame
        n0 = got.size();
        drive(4'b0001, 7'h24, 20);
        drive(4'b0010, 7'h30, 20);
        check("t5_stale_before", stale, 0);
        drive(4'b0000, 7'h7F, TO + 100);
        check("t5_stale", stale, 1);
        drive(4'b0100, 7'h12, 20);
        drive(4'b1000, 7'h02, 20);
        check("t5_seen_cleared", got.size() - n0, 0);
        drive(4'b0001, 7'h78, 20);
        drive(4'b0010, 7'h00, 20);
        repeat (2) @(negedge clk);
        f = last_frame();
        check("t5_count", got.size() - n0, 1);
        check("t5_value", f[15:0], 16'h6587);
        check("t5_stale_clr", stale, 0);

        // Reset in the middle of a scan
        drive(4'b0001, 7'h79, 20);
        drive(4'b0010, 7'h24, 20);
        drive(4'b0100, 7'h30, 20);
        #2 reset = 1'b1;
        #1;
        check("t6_rst_value", {16'h0, out_value}, 32'h0);
        check("t6_rst_flags", {20'h0, out_digit_ok, out_dp, out_valid, err_pattern, err_overrun, stale}, 32'h0);
        sel = 4'b0000;
        seg = 8'hFF;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n0 = got.size();
        drive(4'b1000, 7'h19, 20);
        repeat (2) @(negedge clk);
        check("t6_partial_lost", got.size() - n0, 0);
        drive(4'b0001, 7'h79, 20);
        drive(4'b0010, 7'h24, 20);
        drive(4'b0100, 7'h30, 20);
        repeat (2) @(negedge clk);
        f = last_frame();
        check("t6_count", got.size() - n0, 1);
        check("t6_value", f[15:0], 16'h4321);

        // Randomized scan against a digit-level frame model
        drive(4'b0000, 7'h7F, 5);
        pulse_err_clr();
        got.delete();
        m_seen = 4'h0;
        m_val  = 16'h0;
        m_ok   = 4'h0;
        m_err  = 1'b0;
        begin
            logic [10:0] prev_key;
            int          nonone;
            prev_key = '0;
            nonone   = 0;
            for (int n = 0; n < 80; n++) begin
                logic [3:0] s;
                logic [6:0] g;
                logic       one;
                int         k;
                int         c;
                if (nonone < 2 && $urandom_range(7) == 0) begin
                    s = 4'b0011 << $urandom_range(2);
                    nonone++;
                    one = 1'b0;
                end else begin
                    s = 4'b0001 << $urandom_range(3);
                    nonone = 0;
                    one = 1'b1;
                end
                k = $urandom_range(19);
                if (k < 16) g = GLY[k];
                else if (k == 16) g = 7'h7F;
                else begin
                    do g = 7'($urandom_range(126)); while (glyph_class(g) != 17);
                end
                if ({s, g} == prev_key || $urandom_range(3) == 0) begin
                    drive_raw(4'b0000, 8'($urandom), $urandom_range(1, 5));
                    prev_key = '0;
                end
                drive_raw(s, {1'($urandom_range(1)), g}, $urandom_range(20, 40));
                prev_key = {s, g};
                if (one) begin
                    int i;
                    i = 0;
                    for (int b = 0; b < 4; b++) if (s[b]) i = b;
                    c = glyph_class(g);
                    m_val[4*i +: 4] = (c < 16) ? c[3:0] : 4'h0;
                    m_ok[i]         = (c < 16);
                    if (c == 17) m_err = 1'b1;
                    m_seen[i] = 1'b1;
                    if (m_seen == 4'hF) begin
                        expq.push_back({4'h0, m_ok, m_val});
                        m_seen = 4'h0;
                    end
                end
            end
        end
        drive(4'b0000, 7'h7F, 30);
        check("rnd_count", got.size(), expq.size());
        for (int i = 0; i < expq.size() && i < got.size(); i++) check("rnd_frame", got[i], expq[i]);
        check("rnd_err_pattern", err_pattern, m_err);
        check("rnd_no_ovr", err_overrun, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
- Observes the multiplexed 4-digit seven-segment scan bus (sel/seg) that the CPU display path drives, and rebuilds the displayed hex value.
- It is the receiving end of the display interface. It is used as an on-board debug/self-check monitor and as a bench-side checker.
- Operation: deglitches the scan, decodes segment patterns back to nibbles, assembles 4-digit frames and presents them on a valid/ready output.

Parameters:
- STABLE_CYCLES, 16: consecutive identical synced samples required before a digit is captured (minimum 2).
- TIMEOUT_CYCLES, 200000: cycles without any capture before the partial frame is discarded.
- SEL_ACTIVE_LOW, 0: 1 means sel is active-low one-hot; 0 means active-high.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- sel  in  4  digit select from the scan bus, one-hot; sel[0] is the least significant digit
- seg  in  8  segments, active-low; seg[7] = dp, seg[6:0] = g..a
- out_value  out  16  decoded frame, digit i at [4i+3:4i]
- out_digit_ok  out  4  per-digit flag: the digit decoded to a legal hex glyph
- out_dp  out  4  per-digit decimal point, 1 = lit
- out_valid  out  1  frame available
- out_ready  in  1  consumer accepts the frame
- err_clr  in  1  single-cycle pulse that clears the sticky errors
- err_pattern  out  1  sticky: an illegal non-blank glyph was captured
- err_overrun  out  1  sticky: a completed frame was dropped while the holding register was full
- stale  out  1  sticky: a timeout occurred; cleared by the next frame load

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high. All outputs are 0 while reset is asserted.
- Input path:
  - sel and seg pass through a 2-flop synchronizer.
  - sel is normalized to active-high per SEL_ACTIVE_LOW.
- Stability counter:
  - Compares the synced {sel,seg} with the previous sample. A mismatch loads 0; a match increments, saturating at STABLE_CYCLES.
  - A capture event fires on the single cycle the count goes from STABLE_CYCLES-2 to STABLE_CYCLES-1. There is one capture per stable period.
  - Capture latency from a pin change is 2 sync cycles + STABLE_CYCLES.
  - sel not exactly one-hot (zero bits or multiple bits set): no capture, and the counter keeps running.
- Decode of seg[6:0] (active-low):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (hex).
  - 7F = blank: nibble 0, ok=0, not an error.
  - Any other pattern: nibble 0, ok=0, err_pattern set.
- Capture of digit i writes the nibble, ok and dp into the collect registers and sets seen[i]. Recapturing the same digit before the frame completes overwrites it.
- FSM, COLLECT / HOLD:
  - COLLECT: when seen==4'hF, copy the collect registers to the output registers, assert out_valid, clear seen and go to HOLD.
  - HOLD: out_valid stays high and the outputs stay stable until out_valid&&out_ready. Collection continues in parallel.
  - HOLD, handshake this cycle: if seen==4'hF in the same cycle, load the new frame and remain in HOLD with out_valid=1; otherwise clear out_valid and go to COLLECT.
  - HOLD, no handshake, seen==4'hF: the new frame is dropped, seen is cleared and err_overrun is set.
- Timeout:
  - A counter resets on every capture and saturates.
  - On reaching TIMEOUT_CYCLES with seen!=0: seen is cleared and stale is set.
  - The timeout never affects a frame already held.
- Errors:
  - err_clr clears err_pattern and err_overrun.
  - If a set event and err_clr occur in the same cycle, the set wins.
- Reset mid-frame: seen, counters and the FSM (COLLECT) clear immediately, and any partial frame is lost.

Optional Feature:
- SEGDEC_DP_CAPTURE_EN defined: seg[7] takes part in the stability compare, and out_dp reports ~seg[7] per digit.
- Undefined: seg[7] is masked to 1 before the compare, so dp flicker never blocks capture, and out_dp is tied to 0.

Test Plan:
- Scan 1,2,3,4 (sel 0001→1000; seg 79,24,30,19 with dp off), each held 20 cycles, out_ready=1:
  - out_value=16'h4321 and out_digit_ok=4'hF.
  - out_valid pulses 1 cycle, at 2+16 cycles after the sel=1000 dwell begins.
- Digit 2 toggles between 24 and 00 every 5 cycles (STABLE=16) before settling on 24:
  - No capture during the toggling.
  - Final out_value[11:8]=2.
- Digit 1 = 7F, digit 3 = 55, others legal:
  - out_digit_ok=4'b0101.
  - err_pattern=1, stays 1 until err_clr.
- out_ready=0 across two full scans:
  - First frame held unchanged.
  - err_overrun=1.
  - Releasing out_ready gives 1 handshake, then out_valid=0.
- Scan two digits, then idle 200000 cycles:
  - stale=1 and seen cleared.
  - The next full scan yields a fresh frame and stale=0.
- Assert reset mid-scan after 3 digits:
  - All outputs 0.
  - After release, a frame only appears once all 4 digits are recaptured.
